// File: rtl/branch_resolver_pkg.sv
// Shared constants for the execute-stage branch resolver: default XLEN and the
// RISC-V conditional-branch funct3 encodings.
package branch_resolver_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // 010/011 are the only funct3 values that are not conditional branches
  function automatic logic br_is_legal(input logic [2:0] funct3);
    return (funct3 != 3'b010) && (funct3 != 3'b011);
  endfunction

endpackage

// File: rtl/jcond_queue.sv
// Synchronous FIFO holding predictor updates ({pc, hit, taken}) until the
// predictor consumes them; head data is shown straight from the storage.
module jcond_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves conditional branches at execute, issues a one-cycle fetch redirect on
// a mispredict and feeds the predictor's update stream through jcond_queue.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int QDEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  // exe handshake: a branch is taken in when exe_vld & exe_ready at an edge
  input  logic            exe_vld,
  output logic            exe_ready,
  input  logic [XLEN-1:0] exe_pc,
  input  logic            exe_rvc,
  input  logic [2:0]      exe_funct3,
  input  logic [XLEN-1:0] exe_rs1,
  input  logic [XLEN-1:0] exe_rs2,
  input  logic [XLEN-1:0] exe_imm,
  input  logic            exe_predict,
  output logic            redirect_vld,
  output logic [XLEN-1:0] redirect_pc,
  output logic            jcond_vld,
  output logic [XLEN-1:0] jcond_pc,
  output logic            jcond_hit,
  output logic            jcond_taken
);

  localparam int QW = XLEN + 2;

  logic                    accept;
  logic                    legal;
  logic                    taken;
  logic                    miss;
  logic                    push;
  logic [XLEN-1:0]         target;
  logic [XLEN-1:0]         fallthru;
  logic [QW-1:0]           push_data;
  logic [QW-1:0]           head;
  logic [$clog2(QDEPTH):0] q_count;
  logic                    q_full;
  logic                    q_empty;

  always_comb begin
    taken = 1'b0;
    case (exe_funct3)
      BR_EQ:   taken = (exe_rs1 == exe_rs2);
      BR_NE:   taken = (exe_rs1 != exe_rs2);
      BR_LT:   taken = ($signed(exe_rs1) <  $signed(exe_rs2));
      BR_GE:   taken = ($signed(exe_rs1) >= $signed(exe_rs2));
      BR_LTU:  taken = (exe_rs1 <  exe_rs2);
      BR_GEU:  taken = (exe_rs1 >= exe_rs2);
      default: taken = 1'b0;
    endcase
  end

  assign legal     = br_is_legal(exe_funct3);
  assign accept    = exe_vld & exe_ready;
  assign miss      = taken ^ exe_predict;
  assign push      = accept & legal;
  assign target    = exe_pc + exe_imm;
  assign fallthru  = exe_pc + (exe_rvc ? XLEN'(2) : XLEN'(4));
  assign push_data = {exe_pc, ~miss, taken};

  // registered count only: a pop in the same cycle does not reopen a full queue
  assign exe_ready = ~q_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_vld <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      redirect_vld <= push & miss;
      if (push & miss) begin
        redirect_pc <= taken ? target : fallthru;
      end
    end
  end

  jcond_queue #(
    .DEPTH (QDEPTH),
    .WIDTH (QW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (jcond_vld),
    .pop_data  (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  // the predictor always consumes, so the head pops whenever it is valid
  assign jcond_vld   = ~q_empty;
  assign jcond_pc    = head[QW-1:2];
  assign jcond_hit   = head[1];
  assign jcond_taken = head[0];

  logic unused_count;
  assign unused_count = ^q_count;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: redirect timing, update stream order,
// wrap-around arithmetic, illegal funct3 and mid-operation reset.
module tb_branch_resolver;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            exe_vld;
  logic            exe_ready;
  logic [XLEN-1:0] exe_pc;
  logic            exe_rvc;
  logic [2:0]      exe_funct3;
  logic [XLEN-1:0] exe_rs1;
  logic [XLEN-1:0] exe_rs2;
  logic [XLEN-1:0] exe_imm;
  logic            exe_predict;
  logic            redirect_vld;
  logic [XLEN-1:0] redirect_pc;
  logic            jcond_vld;
  logic [XLEN-1:0] jcond_pc;
  logic            jcond_hit;
  logic            jcond_taken;

  int checks = 0;
  int errors = 0;

  logic [XLEN+1:0] exp_q[$];

  branch_resolver #(.XLEN(XLEN), .QDEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .exe_vld      (exe_vld),
    .exe_ready    (exe_ready),
    .exe_pc       (exe_pc),
    .exe_rvc      (exe_rvc),
    .exe_funct3   (exe_funct3),
    .exe_rs1      (exe_rs1),
    .exe_rs2      (exe_rs2),
    .exe_imm      (exe_imm),
    .exe_predict  (exe_predict),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .jcond_vld    (jcond_vld),
    .jcond_pc     (jcond_pc),
    .jcond_hit    (jcond_hit),
    .jcond_taken  (jcond_taken)
  );

  always #5 clk = ~clk;

  // drive on the falling edge, present for one rising edge, sample 1 ns after it
  task automatic send(input logic [2:0] f3, input logic [XLEN-1:0] pc,
                      input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                      input logic [XLEN-1:0] imm, input logic rvc, input logic pred);
    @(negedge clk);
    exe_vld     = 1'b1;
    exe_funct3  = f3;
    exe_pc      = pc;
    exe_rs1     = rs1;
    exe_rs2     = rs2;
    exe_imm     = imm;
    exe_rvc     = rvc;
    exe_predict = pred;
    @(posedge clk);
    #1;
    exe_vld = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    exe_vld = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_redirect(input string name, input logic vld, input logic [XLEN-1:0] pc);
    checks++;
    if (redirect_vld !== vld) begin
      errors++;
      $display("FAIL %s redirect_vld: got %b expected %b", name, redirect_vld, vld);
    end
    if (vld) begin
      checks++;
      if (redirect_pc !== pc) begin
        errors++;
        $display("FAIL %s redirect_pc: got %h expected %h", name, redirect_pc, pc);
      end
    end
  endtask

  task automatic check_jcond(input string name, input logic vld, input logic [XLEN-1:0] pc,
                             input logic hit, input logic tk);
    checks++;
    if (jcond_vld !== vld) begin
      errors++;
      $display("FAIL %s jcond_vld: got %b expected %b", name, jcond_vld, vld);
    end
    if (vld) begin
      checks++;
      if ({jcond_pc, jcond_hit, jcond_taken} !== {pc, hit, tk}) begin
        errors++;
        $display("FAIL %s jcond: got pc=%h hit=%b taken=%b expected pc=%h hit=%b taken=%b",
                 name, jcond_pc, jcond_hit, jcond_taken, pc, hit, tk);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_redirect("reset", 1'b0, '0);
    checks++;
    if (redirect_pc !== '0) begin
      errors++;
      $display("FAIL reset redirect_pc: got %h expected 0", redirect_pc);
    end
    check_jcond("reset", 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (exe_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset exe_ready: got %b expected 1", exe_ready);
    end
  endtask

  task automatic test_beq();
    send(3'b000, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 1'b0);
    check_redirect("beq", 1'b1, 32'h120);
    check_jcond("beq", 1'b1, 32'h100, 1'b0, 1'b1);
    idle_cycle();
    check_redirect("beq_pulse", 1'b0, '0);
    check_jcond("beq_drain", 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_signed_unsigned();
    send(3'b100, 32'h140, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 1'b1);
    check_redirect("blt", 1'b0, '0);
    check_jcond("blt", 1'b1, 32'h140, 1'b1, 1'b1);
    send(3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 1'b1);
    check_redirect("bltu", 1'b1, 32'h202);
    check_jcond("bltu", 1'b1, 32'h200, 1'b0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_wrap();
    send(3'b001, 32'hFFFF_FFFC, 32'd1, 32'd2, 32'd8, 1'b0, 1'b0);
    check_redirect("wrap_target", 1'b1, 32'h0000_0004);
    check_jcond("wrap_target", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
    send(3'b001, 32'hFFFF_FFFC, 32'd7, 32'd7, 32'd8, 1'b0, 1'b1);
    check_redirect("wrap_fallthru", 1'b1, 32'h0000_0000);
    check_jcond("wrap_fallthru", 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    idle_cycle();
  endtask

  task automatic test_illegal();
    send(3'b010, 32'h300, 32'd1, 32'd2, 32'h10, 1'b0, 1'b1);
    check_redirect("illegal_010", 1'b0, '0);
    check_jcond("illegal_010", 1'b0, '0, 1'b0, 1'b0);
    send(3'b011, 32'h304, 32'd1, 32'd1, 32'h10, 1'b0, 1'b1);
    check_redirect("illegal_011", 1'b0, '0);
    check_jcond("illegal_011", 1'b0, '0, 1'b0, 1'b0);
  endtask

  // five branches with exe_vld held high; expected {pc, hit, taken} hand-computed
  task automatic test_back_to_back();
    logic [2:0]      f3_tab [5];
    logic [XLEN+1:0] exp_tab [5];
    logic [XLEN+1:0] exp_item;
    f3_tab[0] = 3'b000; exp_tab[0] = {32'h400, 1'b1, 1'b1};  // BEQ 3==3 taken
    f3_tab[1] = 3'b101; exp_tab[1] = {32'h404, 1'b1, 1'b1};  // BGE taken
    f3_tab[2] = 3'b111; exp_tab[2] = {32'h408, 1'b1, 1'b1};  // BGEU taken
    f3_tab[3] = 3'b001; exp_tab[3] = {32'h40C, 1'b0, 1'b0};  // BNE not taken
    f3_tab[4] = 3'b100; exp_tab[4] = {32'h410, 1'b0, 1'b0};  // BLT not taken
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exe_vld     = 1'b1;
      exe_funct3  = f3_tab[i];
      exe_pc      = 32'h400 + 32'(4 * i);
      exe_rs1     = 32'd3;
      exe_rs2     = 32'd3;
      exe_imm     = 32'h80;
      exe_rvc     = 1'b0;
      exe_predict = 1'b1;
      checks++;
      if (exe_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, exe_ready);
      end
      exp_q.push_back(exp_tab[i]);
      @(posedge clk);
      #1;
      exp_item = exp_q.pop_front();
      check_jcond($sformatf("b2b[%0d]", i), 1'b1, exp_item[XLEN+1:2], exp_item[1], exp_item[0]);
      check_redirect($sformatf("b2b_redir[%0d]", i), ~exp_item[1], 32'h404 + 32'(4 * i));
    end
    idle_cycle();
    check_jcond("b2b_drained", 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (exe_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_end: got %b expected 1", exe_ready);
    end
  endtask

  task automatic test_reset_mid();
    send(3'b000, 32'h500, 32'd1, 32'd1, 32'h10, 1'b0, 1'b0);
    @(negedge clk);
    rst         = 1'b1;
    exe_vld     = 1'b1;
    exe_funct3  = 3'b000;
    exe_pc      = 32'h504;
    exe_rs1     = 32'd2;
    exe_rs2     = 32'd2;
    exe_predict = 1'b0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    exe_vld = 1'b0;
    check_redirect("rst_mid", 1'b0, '0);
    check_jcond("rst_mid", 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (exe_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid exe_ready: got %b expected 1", exe_ready);
    end
    idle_cycle();
    check_jcond("rst_mid_after", 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    rst         = 1'b1;
    exe_vld     = 1'b0;
    exe_pc      = '0;
    exe_rvc     = 1'b0;
    exe_funct3  = 3'b000;
    exe_rs1     = '0;
    exe_rs2     = '0;
    exe_imm     = '0;
    exe_predict = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_beq();
    test_signed_unsigned();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
